choice_update_unit: RTL and testbench

CHOICE_UPDATE_UNIT -- requirements
Module: choice_update_unit

---
 rtl/tournament_pkg.sv | 14 +
 rtl/inflight_fifo.sv | 36 +++
 rtl/choice_update_unit.sv | 76 +++++++
 tb/tb_choice_update_unit.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/tournament_pkg.sv
// tournament_pkg: shared entry type, depth default and choice encoding for the tournament predictor.
package tournament_pkg;
  localparam int DEPTH_DEFAULT = 8;
  localparam logic CHOICE_LOCAL = 1'b0;
  localparam logic CHOICE_GLOBAL = 1'b1;
  typedef struct packed {
    logic lcl;
    logic glb;
    logic chc;
  } entry_t;
  function automatic logic selected(entry_t e);
    return (e.chc == CHOICE_GLOBAL) ? e.glb : e.lcl;
  endfunction
endpackage

// File: rtl/inflight_fifo.sv
// inflight_fifo: in-order store of predicted branches awaiting resolution; push/pop arrive pre-qualified.
module inflight_fifo
  import tournament_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   din,
  output entry_t                   dout,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [PW-1:0] head, tail;
  assign dout = mem[head];
  assign full = occupancy == (PW+1)'(DEPTH);
  assign empty = occupancy == '0;
  always_ff @(posedge clock)
    if (push) mem[tail] <= din;
  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clock)
    if (reset) begin
      head <= '0;
      tail <= '0;
      occupancy <= '0;
    end else begin
      head <= head + PW'(pop);
      tail <= tail + PW'(push);
      occupancy <= occupancy + (PW+1)'(push) - (PW+1)'(pop);
    end
endmodule

// File: rtl/choice_update_unit.sv
// choice_update_unit: tracks in-flight tournament predictions and emits choice-training/mispredict pulses.
// Define CHOICE_UPDATE_STATS_EN to add saturating 32-bit statistics counters.
module choice_update_unit
  import tournament_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   predict_valid,
  input  logic                   local_pred,
  input  logic                   global_pred,
  input  logic                   choice,
  output logic                   predict_ready,
  output logic                   final_prediction,
  input  logic                   resolve_valid,
  input  logic                   actual_taken,
  output logic                   choice_update_valid,
  output logic                   choice_update_global,
  output logic                   mispredict,
`ifdef CHOICE_UPDATE_STATS_EN
  output logic [31:0]            stat_resolved,
  output logic [31:0]            stat_mispredict,
  output logic [31:0]            stat_choice_update,
`endif
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow_err,
  output logic                   underflow_err
);
  entry_t new_entry, head_entry;
  logic full, empty, push, pop, split, wrong;
  assign new_entry = '{lcl: local_pred, glb: global_pred, chc: choice};
  assign final_prediction = (choice == CHOICE_GLOBAL) ? global_pred : local_pred;
  assign predict_ready = !full;
  assign push = predict_valid && !full;
  assign pop = resolve_valid && !empty;
  assign split = head_entry.lcl != head_entry.glb;
  assign wrong = selected(head_entry) != actual_taken;
  inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(new_entry),
    .dout(head_entry),
    .occupancy(occupancy),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clock)
    if (reset) begin
      choice_update_valid <= 1'b0;
      choice_update_global <= 1'b0;
      mispredict <= 1'b0;
      overflow_err <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      choice_update_valid <= pop && split;
      choice_update_global <= pop && split && (head_entry.glb == actual_taken);
      mispredict <= pop && wrong;
      overflow_err <= overflow_err || (predict_valid && full);
      underflow_err <= underflow_err || (resolve_valid && empty);
    end
`ifdef CHOICE_UPDATE_STATS_EN
  always_ff @(posedge clock)
    if (reset) begin
      stat_resolved <= '0;
      stat_mispredict <= '0;
      stat_choice_update <= '0;
    end else begin
      if (pop && ~&stat_resolved) stat_resolved <= stat_resolved + 32'd1;
      if (pop && wrong && ~&stat_mispredict) stat_mispredict <= stat_mispredict + 32'd1;
      if (pop && split && ~&stat_choice_update) stat_choice_update <= stat_choice_update + 32'd1;
    end
`endif
endmodule

// File: tb/tb_choice_update_unit.sv
// tb_choice_update_unit: directed bench for choice_update_unit at DEPTH=8 with a queue scoreboard.
module tb_choice_update_unit;
  logic clock = 0, reset = 1, predict_valid = 0, local_pred = 0, global_pred = 0, choice = 0;
  logic resolve_valid = 0, actual_taken = 0;
  logic predict_ready, final_prediction, choice_update_valid, choice_update_global, mispredict;
  logic overflow_err, underflow_err;
  logic [3:0] occupancy;
`ifdef CHOICE_UPDATE_STATS_EN
  logic [31:0] stat_resolved, stat_mispredict, stat_choice_update;
`endif
  int total = 0, bad = 0;
  logic [2:0] q[$];
  always #5 clock = ~clock;
  choice_update_unit #(.DEPTH(8)) dut (
    .clock(clock),
    .reset(reset),
    .predict_valid(predict_valid),
    .local_pred(local_pred),
    .global_pred(global_pred),
    .choice(choice),
    .predict_ready(predict_ready),
    .final_prediction(final_prediction),
    .resolve_valid(resolve_valid),
    .actual_taken(actual_taken),
    .choice_update_valid(choice_update_valid),
    .choice_update_global(choice_update_global),
    .mispredict(mispredict),
`ifdef CHOICE_UPDATE_STATS_EN
    .stat_resolved(stat_resolved),
    .stat_mispredict(stat_mispredict),
    .stat_choice_update(stat_choice_update),
`endif
    .occupancy(occupancy),
    .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  function automatic logic [2:0] pat(int n);
    return 3'(n * 5 + 3);
  endfunction
  // e = {local, global, choice}; expected results come from the scoreboard queue
  task automatic cyc(input logic pv, input logic [2:0] e, input logic rv, input logic act, input string tag);
    logic [2:0] h;
    logic full, pop, split;
    predict_valid = pv;
    {local_pred, global_pred, choice} = e;
    resolve_valid = rv;
    actual_taken = act;
    #1;
    full = q.size() == 8;
    chk({tag, ":ready"}, predict_ready, !full);
    chk({tag, ":final"}, final_prediction, e[0] ? e[1] : e[2]);
    pop = rv && q.size() != 0;
    h = pop ? q.pop_front() : 3'b000;
    if (pv && !full) q.push_back(e);
    split = h[2] != h[1];
    tick();
    chk({tag, ":cuv"}, choice_update_valid, pop && split);
    chk({tag, ":cug"}, choice_update_global, pop && split && (h[1] == act));
    chk({tag, ":mis"}, mispredict, pop && ((h[0] ? h[1] : h[2]) != act));
    chk({tag, ":occ"}, occupancy, q.size());
    predict_valid = 0;
    resolve_valid = 0;
  endtask
  initial begin
    repeat (2) tick();
    reset = 0;
    chk("rst_occ", occupancy, 0);
    chk("rst_ready", predict_ready, 1);
    chk("rst_cuv", choice_update_valid, 0);
    chk("rst_cug", choice_update_global, 0);
    chk("rst_mis", mispredict, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_unf", underflow_err, 0);
    // L=1 G=0 C=0, resolve not-taken: global right, local wrong, final wrong
    cyc(1, 3'b100, 0, 0, "p1");
    cyc(0, 3'b000, 0, 0, "idle1");
    cyc(0, 3'b000, 1, 0, "r1");
    chk("r1_cuv_hand", choice_update_valid, 1);
    chk("r1_cug_hand", choice_update_global, 1);
    chk("r1_mis_hand", mispredict, 1);
    cyc(0, 3'b000, 0, 0, "quiet");
    // agreeing predictors: no training, still a mispredict
    cyc(1, 3'b111, 0, 0, "p2");
    cyc(0, 3'b000, 1, 0, "r2");
    chk("r2_mis_hand", mispredict, 1);
    chk("r2_cuv_hand", choice_update_valid, 0);
    // resolve on empty with a same-cycle push
    cyc(1, 3'b011, 1, 1, "unf");
    chk("unf_flag", underflow_err, 1);
    chk("unf_occ_hand", occupancy, 1);
    chk("unf_cuv_hand", choice_update_valid, 0);
    cyc(0, 3'b000, 1, 1, "r3");
    chk("r3_cug_hand", choice_update_global, 1);
    chk("r3_mis_hand", mispredict, 0);
    // fill, overflow, then push-while-full with a pop
    for (int i = 0; i < 8; i++) cyc(1, pat(i), 0, 0, "fill");
    chk("full_ready", predict_ready, 0);
    chk("full_occ", occupancy, 8);
    chk("ovf_before", overflow_err, 0);
    cyc(1, pat(8), 0, 0, "ovf");
    chk("ovf_flag", overflow_err, 1);
    chk("ovf_occ", occupancy, 8);
    for (int i = 0; i < 8; i++) cyc(i == 0, pat(9), 1, 0, "drain");
    chk("drain_occ", occupancy, 0);
    // steady push+pop at occupancy 4 across the pointer wrap
    for (int j = 0; j < 4; j++) cyc(1, pat(j + 20), 0, 0, "pre");
    for (int k = 0; k < 12; k++) cyc(1, pat(k + 24), 1, k[0], "wrap");
    chk("wrap_occ", occupancy, 4);
    // reset during a resolve with 3 in flight
    cyc(0, 3'b000, 1, 1, "to3");
    chk("to3_occ", occupancy, 3);
    reset = 1;
    resolve_valid = 1;
    actual_taken = 0;
    tick();
    reset = 0;
    resolve_valid = 0;
    q.delete();
    chk("mr_cuv", choice_update_valid, 0);
    chk("mr_mis", mispredict, 0);
    chk("mr_occ", occupancy, 0);
    chk("mr_ready", predict_ready, 1);
    chk("mr_ovf", overflow_err, 0);
    cyc(1, 3'b010, 0, 0, "post_p");
    cyc(0, 3'b000, 1, 1, "post_r");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
